lt24_lcd_reset_seq: RTL and testbench
=====================================

# lt24_lcd_reset_seq

Timed reset sequencer for the LT24 (ILI9341) panel. Sits directly downstream of the LCD_RESET_N PIO: it consumes the PIO's `out_port` level as a reset request and drives the physical panel reset pin. It enforces the controller's minimum reset-low width and post-release wait. It exposes a `ready` qualifier that gates the LCD data path, plus a small Avalon-MM status/control slave.

## Interface
- `T_LOW_CYC`, default 500: minimum `lcd_reset_n` low time in clk cycles (10 µs at 50 MHz); must be ≥2.
- `T_WAIT_CYC`, default 6000000: wait after release before the panel is usable (120 ms at 50 MHz); must be ≥2.
- `CNT_W`, default 23: delay counter width; must satisfy 2^CNT_W > max(T_LOW_CYC, T_WAIT_CYC).
- `clk`, input, 1: single clock for all logic.
- `reset`, input, 1: asynchronous, active-high.
- `req_n`, input, 1: reset request from PIO `out_port`; 0 means hold the panel in reset. Same clock domain, no synchroniser.
- `address`, input, 2: Avalon-MM word address.
- `chipselect`, input, 1: Avalon-MM select.
- `write_n`, input, 1: Avalon-MM write strobe, active-low.
- `writedata`, input, 32: Avalon-MM write data.
- `readdata`, output, 32: Avalon-MM read data, combinational, zero wait states.
- `lcd_reset_n`, output, 1: registered panel reset pin.
- `ready`, output, 1: registered; 1 only when the panel may be accessed.
- `busy`, output, 1: 1 in ASSERT or WAIT.

## Operation
- States: ASSERT, WAIT, READY. Reset puts the block in ASSERT with cnt=0, `lcd_reset_n`=0, `ready`=0, `busy`=1, seq_count=0.
- ASSERT:
  - `lcd_reset_n`=0.
  - cnt increments, saturating at T_LOW_CYC−1.
  - Go to WAIT at the edge where cnt==T_LOW_CYC−1 and eff_req_n==1. On that edge cnt←0 and `lcd_reset_n`←1.
- WAIT:
  - cnt increments.
  - If eff_req_n==0, go to ASSERT with cnt←0 and `lcd_reset_n`←0. This abort takes priority over completion.
  - At cnt==T_WAIT_CYC−1, go to READY with `ready`←1 and seq_count←seq_count+1 (16 bits, wraps FFFF→0000).
- READY: if eff_req_n==0, go to ASSERT with cnt←0, `ready`←0, `lcd_reset_n`←0.
- eff_req_n = `req_n` AND NOT sw_pulse.
  - sw_pulse is high for exactly the cycle in which a write to address 0 has writedata[0]=1.
  - A software pulse therefore behaves as a one-cycle `req_n` low.
- Register map:
  - addr 0 read: {29'b0, busy, ready, lcd_reset_n}.
  - addr 1 read: {16'b0, seq_count}.
  - addr 1 write: any write clears seq_count.
  - addr 2–3 read 0; writes to addr 2–3 are ignored.
- Clear vs. completion in the same cycle: the clear wins and seq_count=0.
- `busy` is decoded from the state register, not registered separately.

## Timing
- `req_n` falls at edge E (sampled) → `lcd_reset_n` and `ready` go to 0 at E+1.
- `req_n` is low for a short pulse (high again by the first ASSERT cycle) → `lcd_reset_n` stays low exactly T_LOW_CYC cycles.
- `req_n` held low for N cycles → `lcd_reset_n` stays low for max(T_LOW_CYC, N) cycles.
- `lcd_reset_n` rising edge → `ready` rises exactly T_WAIT_CYC cycles later.
- After `reset` deasserts with `req_n`=1 → `lcd_reset_n` rises T_LOW_CYC cycles later; `ready` rises T_LOW_CYC+T_WAIT_CYC cycles later.
- `reset` asserted mid-sequence → all outputs return to their reset values immediately (asynchronous).
- `readdata` reflects register state in the same cycle as the read.

## Structure
- Package `lt24_lcd_pkg` holds:
  - the state enum (ASSERT/WAIT/READY);
  - register address constants (ADDR_STATUS=0, ADDR_SEQCNT=1);
  - status bit indices.
- One natural sub-module, `lt24_delay_counter`: clear, enable and saturate-at-limit counter, with a `hit` output and the limit as an input. It is shared by the ASSERT and WAIT phases.

## Test plan
Bench parameters: T_LOW_CYC=4, T_WAIT_CYC=8, CNT_W=4.
- Release `reset` with `req_n`=1 → `lcd_reset_n` low 4 cycles, then high; `ready` rises 8 cycles later; addr 1 reads 0x0001; addr 0 reads 0x3 (busy=0, ready=1, lcd_reset_n=1).
- In READY, drive `req_n` low for 1 cycle → `lcd_reset_n` low exactly 4 cycles, then 8 cycles to `ready`; seq_count=2.
- Drive `req_n` low for 10 cycles → `lcd_reset_n` low 10 cycles; `busy`=1 throughout ASSERT and WAIT.
- At WAIT cycle 5, drop `req_n` → state returns to ASSERT, `ready` never pulses, seq_count unchanged; the full 4+8 sequence follows once `req_n`=1.
- Write 0x1 to addr 0 in READY → same response as a 1-cycle `req_n` pulse. Write addr 1 in the same cycle as completion → seq_count reads 0.
- Assert `reset` at WAIT cycle 3 → `lcd_reset_n`=0, `ready`=0, seq_count=0 immediately; then the normal startup sequence follows.

Source files
------------

// File: rtl/lt24_lcd_reset_seq_pkg.sv
// Shared types and register map for the LT24 panel reset sequencer.
// Holds the sequencer states, Avalon word addresses and status bit positions.
package lt24_lcd_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_WAIT   = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_SEQCNT = 2'd1;

  localparam int STAT_RST_N_BIT = 0;
  localparam int STAT_READY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;

endpackage

// File: rtl/lt24_delay_counter.sv
// Up-counter with synchronous clear that saturates at a run-time limit.
// Shared between the reset-low and post-release wait phases.
module lt24_delay_counter #(
  parameter int CNT_W = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  logic [CNT_W-1:0] cnt;

  assign hit = (cnt == limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !hit) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lt24_lcd_reset_seq.sv
// Timed reset sequencer for the LT24 (ILI9341) panel reset pin, with a
// ready qualifier for the LCD data path and an Avalon-MM status/control slave.
module lt24_lcd_reset_seq
  import lt24_lcd_pkg::*;
#(
  parameter int T_LOW_CYC  = 500,
  parameter int T_WAIT_CYC = 6000000,
  parameter int CNT_W      = 23
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        lcd_reset_n,
  output logic        ready,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LOW_LIM  = CNT_W'(T_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(T_WAIT_CYC - 1);

  state_t           state, state_next;
  logic             wr, sw_pulse, eff_req_n, seq_clr;
  logic             cnt_clr, cnt_hit, done;
  logic [CNT_W-1:0] cnt_limit;
  logic [15:0]      seq_count;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign sw_pulse     = wr && (address == ADDR_STATUS) && writedata[0];
  assign eff_req_n    = req_n & ~sw_pulse;
  assign seq_clr      = wr && (address == ADDR_SEQCNT);
  assign busy         = (state != ST_READY);
  assign unused_wdata = ^writedata[31:1];

  lt24_delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (busy),
    .limit (cnt_limit),
    .hit   (cnt_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_ASSERT;
    end else begin
      state <= state_next;
    end
  end

  // Every state change restarts the counter so each phase times from zero.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_limit  = LOW_LIM;
    done       = 1'b0;
    case (state)
      ST_ASSERT: begin
        if (cnt_hit && eff_req_n) begin
          state_next = ST_WAIT;
          cnt_clr    = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_limit = WAIT_LIM;
        if (!eff_req_n) begin
          state_next = ST_ASSERT;
          cnt_clr    = 1'b1;
        end else if (cnt_hit) begin
          state_next = ST_READY;
          cnt_clr    = 1'b1;
          done       = 1'b1;
        end
      end
      ST_READY: begin
        if (!eff_req_n) begin
          state_next = ST_ASSERT;
          cnt_clr    = 1'b1;
        end
      end
      default: begin
        state_next = ST_ASSERT;
        cnt_clr    = 1'b1;
      end
    endcase
  end

  // Pin and qualifier are registered from the next state so they switch on
  // the same edge as the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcd_reset_n <= 1'b0;
      ready       <= 1'b0;
      seq_count   <= 16'd0;
    end else begin
      lcd_reset_n <= (state_next != ST_ASSERT);
      ready       <= (state_next == ST_READY);
      if (seq_clr) begin
        seq_count <= 16'd0;
      end else if (done) begin
        seq_count <= seq_count + 16'd1;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_STATUS: begin
        readdata[STAT_RST_N_BIT] = lcd_reset_n;
        readdata[STAT_READY_BIT] = ready;
        readdata[STAT_BUSY_BIT]  = busy;
      end
      ADDR_SEQCNT: readdata[15:0] = seq_count;
      default:     readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_lt24_lcd_reset_seq.sv
// Self-checking bench for lt24_lcd_reset_seq with short timing parameters.
module tb_lt24_lcd_reset_seq;
  import lt24_lcd_pkg::*;

  localparam int T_LOW  = 4;
  localparam int T_WAIT = 8;
  localparam int CW     = 4;

  logic        clk, reset, req_n, chipselect, write_n;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic        lcd_reset_n, ready, busy;

  lt24_lcd_reset_seq #(
    .T_LOW_CYC  (T_LOW),
    .T_WAIT_CYC (T_WAIT),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_n       (req_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .lcd_reset_n (lcd_reset_n),
    .ready       (ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int from_rst;
    int req_low;
    int sw;
    int req2_at;
    int clr_at;
    int exp_low;
    int exp_wait;
    int exp_total;
    int exp_seq;
  } vec_t;

  typedef struct {
    string name;
    int    exp;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   tests  = 0;
  int   failed = 0;

  task automatic check_val(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_push(input string name, input int exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic sb_check(input int act);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard_empty: got %0d, expected a queued entry", act);
    end else begin
      e = sb.pop_front();
      check_val(e.name, act, e.exp);
    end
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output int val);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    #1;
    val = (^readdata === 1'bx) ? -1 : int'(readdata);
    chipselect = 1'b0;
  endtask

  // One request/response sequence: drive the stimulus described by v,
  // measure pulse widths at negedges and compare against the queued values.
  task automatic run_vec(input vec_t v, input int idx);
    int   low, rise_k, ready_k, busy_err, val;
    logic prev_lcd, seen_low;
    string tag;
    tag = $sformatf("v%0d", idx);
    sb_push({tag, "_low_cycles"},   v.exp_low);
    sb_push({tag, "_wait_cycles"},  v.exp_wait);
    sb_push({tag, "_ready_cycle"},  v.exp_total);
    sb_push({tag, "_seq_count"},    v.exp_seq);
    sb_push({tag, "_status"},       3);
    sb_push({tag, "_busy_errors"},  0);
    low = 0; rise_k = -1; ready_k = -1; busy_err = 0;
    seen_low = 1'b0; prev_lcd = 1'b1;
    @(negedge clk);
    if (v.from_rst != 0) reset = 1'b0;
    if (v.req_low > 0) req_n = 1'b0;
    if (v.sw != 0) begin
      chipselect = 1'b1; write_n = 1'b0; address = ADDR_STATUS; writedata = 32'd1;
    end
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (v.req_low > 0 && k == v.req_low) req_n = 1'b1;
        if (v.req2_at > 0 && k == v.req2_at) req_n = 1'b0;
        if (v.req2_at > 0 && k == v.req2_at + 1) req_n = 1'b1;
        if (v.sw != 0 && k == 1) bus_idle();
        if (v.clr_at > 0 && k == v.clr_at) begin
          chipselect = 1'b1; write_n = 1'b0; address = ADDR_SEQCNT; writedata = 32'd0;
        end
        if (v.clr_at > 0 && k == v.clr_at + 1) bus_idle();
      end
      if (lcd_reset_n === 1'b0) begin
        low++;
        seen_low = 1'b1;
      end else if (seen_low && prev_lcd === 1'b0) begin
        rise_k = k;
      end
      prev_lcd = lcd_reset_n;
      if (busy !== ~ready) busy_err++;
      if (lcd_reset_n === 1'b0 && ready === 1'b1) busy_err++;
      if (seen_low && ready === 1'b1) begin
        ready_k = k;
        break;
      end
    end
    bus_idle();
    sb_check(low);
    sb_check((ready_k >= 0 && rise_k >= 0) ? ready_k - rise_k : -1);
    sb_check(ready_k);
    bus_read(ADDR_SEQCNT, val);
    sb_check(val);
    bus_read(ADDR_STATUS, val);
    sb_check(val);
    sb_check(busy_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int val;
    reset = 1'b1;
    req_n = 1'b1;
    bus_idle();

    //          rst req sw req2 clr low wait total seq
    vecs[0] = '{1,  0,  0, 0,   0,  4,  8,   12,   1};
    vecs[1] = '{0,  1,  0, 0,   0,  4,  8,   13,   2};
    vecs[2] = '{0,  10, 0, 0,   0,  10, 8,   19,   3};
    vecs[3] = '{0,  0,  1, 0,   0,  4,  8,   13,   4};
    vecs[4] = '{0,  4,  0, 0,   0,  4,  8,   13,   5};
    vecs[5] = '{0,  1,  0, 10,  0,  8,  8,   23,   6};
    vecs[6] = '{0,  1,  0, 0,   12, 4,  8,   13,   0};
    vecs[7] = '{0,  2,  0, 0,   0,  4,  8,   13,   1};

    repeat (3) @(negedge clk);
    check_val("rst_lcd_reset_n", int'(lcd_reset_n), 0);
    check_val("rst_ready", int'(ready), 0);
    check_val("rst_busy", int'(busy), 1);
    bus_read(ADDR_STATUS, val);
    check_val("rst_status", val, 4);
    bus_read(ADDR_SEQCNT, val);
    check_val("rst_seq_count", val, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Asynchronous reset while waiting after release.
    @(negedge clk);
    req_n = 1'b0;
    @(negedge clk);
    req_n = 1'b1;
    repeat (7) @(negedge clk);
    check_val("midwait_lcd_reset_n_pre", int'(lcd_reset_n), 1);
    check_val("midwait_ready_pre", int'(ready), 0);
    reset = 1'b1;
    #1;
    check_val("midwait_lcd_reset_n", int'(lcd_reset_n), 0);
    check_val("midwait_ready", int'(ready), 0);
    check_val("midwait_busy", int'(busy), 1);
    bus_read(ADDR_SEQCNT, val);
    check_val("midwait_seq_count", val, 0);
    run_vec(vecs[0], 8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
